// File: rtl/idct_block_arbiter.sv
// Shares one wide IDCT stream core between two requesters, one 8-row block at a time.
// Optional per-requester completed-block counters are enabled by defining IDCT_ARB_STATS_EN.
module idct_block_arbiter #(
    parameter int WIN       = 16,
    parameter int WOUT      = 9,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
`ifdef IDCT_ARB_STATS_EN
    output logic [15:0]         blk_cnt0,
    output logic [15:0]         blk_cnt1,
`endif
    input  logic [WIN*8-1:0]    s0_tdata,
    input  logic                s0_tvalid,
    output logic                s0_tready,
    input  logic [WIN*8-1:0]    s1_tdata,
    input  logic                s1_tvalid,
    output logic                s1_tready,
    output logic [WOUT*8-1:0]   m0_tdata,
    output logic                m0_tvalid,
    input  logic                m0_tready,
    output logic [WOUT*8-1:0]   m1_tdata,
    output logic                m1_tvalid,
    input  logic                m1_tready,
    output logic [WIN*8-1:0]    core_s_tdata,
    output logic                core_s_tvalid,
    input  logic                core_s_tready,
    input  logic [WOUT*8-1:0]   core_m_tdata,
    input  logic                core_m_tvalid,
    output logic                core_m_tready,
    output logic                err
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             grant_r;
    logic             last_r;
    logic             winner_s;
    logic             start_s;
    logic [2:0]       in_beat_r;
    logic [2:0]       out_beat_r;
    logic             tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;
    logic             full_s;
    logic             empty_s;
    logic             head_s;
    logic             in_acc_s;
    logic             out_acc_s;
    logic             pop_s;

    assign full_s    = (count_r == CNT_W'(TAG_DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign head_s    = tag_mem_r[rd_ptr_r];
    assign in_acc_s  = core_s_tvalid && core_s_tready;
    assign out_acc_s = !empty_s && core_m_tvalid && core_m_tready;
    assign pop_s     = out_acc_s && (out_beat_r == 3'd7);
    assign err       = err_r;

    // Round-robin pick and block-level FSM; full is judged before any same-cycle pop.
    always_comb begin
        winner_s     = 1'b0;
        start_s      = 1'b0;
        state_next_s = state_r;
        if (s0_tvalid && s1_tvalid) begin
            winner_s = ~last_r;
        end else if (s1_tvalid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if ((s0_tvalid || s1_tvalid) && !full_s) begin
                    start_s      = 1'b1;
                    state_next_s = XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (in_acc_s && (in_beat_r == 3'd7)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = XFER;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Forward mux: only the granted requester sees the core during a block.
    always_comb begin
        core_s_tdata  = {(WIN*8){1'b0}};
        core_s_tvalid = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        if (state_r == XFER) begin
            if (grant_r) begin
                core_s_tdata  = s1_tdata;
                core_s_tvalid = s1_tvalid;
                s1_tready     = core_s_tready;
            end else begin
                core_s_tdata  = s0_tdata;
                core_s_tvalid = s0_tvalid;
                s0_tready     = core_s_tready;
            end
        end else begin
            core_s_tvalid = 1'b0;
        end
    end

    // Return mux steered by the tag at the FIFO head; untagged core output is drained.
    always_comb begin
        m0_tdata      = {(WOUT*8){1'b0}};
        m0_tvalid     = 1'b0;
        m1_tdata      = {(WOUT*8){1'b0}};
        m1_tvalid     = 1'b0;
        core_m_tready = 1'b1;
        if (!empty_s) begin
            if (head_s) begin
                m1_tdata      = core_m_tdata;
                m1_tvalid     = core_m_tvalid;
                core_m_tready = m1_tready;
            end else begin
                m0_tdata      = core_m_tdata;
                m0_tvalid     = core_m_tvalid;
                core_m_tready = m0_tready;
            end
        end else begin
            core_m_tready = 1'b1;
        end
    end

    // FSM state, grant/last history and input beat counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            grant_r   <= 1'b0;
            last_r    <= 1'b1;
            in_beat_r <= 3'd0;
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                grant_r <= winner_s;
                last_r  <= winner_s;
            end
            if (in_acc_s) begin
                in_beat_r <= in_beat_r + 3'd1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read below the occupancy count.
    always_ff @(posedge clock) begin
        if (start_s) begin
            tag_mem_r[wr_ptr_r] <= winner_s;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (start_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({start_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Result beat counter and sticky error for output with no owner.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_beat_r <= 3'd0;
            err_r      <= 1'b0;
        end else begin
            if (out_acc_s) begin
                out_beat_r <= out_beat_r + 3'd1;
            end
            if (empty_s && core_m_tvalid) begin
                err_r <= 1'b1;
            end
        end
    end

`ifdef IDCT_ARB_STATS_EN
    logic [15:0] blk_cnt0_r;
    logic [15:0] blk_cnt1_r;

    // Completed result blocks per requester, wrapping at 16 bits.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blk_cnt0_r <= 16'd0;
            blk_cnt1_r <= 16'd0;
        end else begin
            if (pop_s && !head_s) begin
                blk_cnt0_r <= blk_cnt0_r + 16'd1;
            end
            if (pop_s && head_s) begin
                blk_cnt1_r <= blk_cnt1_r + 16'd1;
            end
        end
    end

    assign blk_cnt0 = blk_cnt0_r;
    assign blk_cnt1 = blk_cnt1_r;
`endif

endmodule

// File: tb/tb_idct_block_arbiter.sv
// Directed bench for idct_block_arbiter: a pass-through core model feeds a scoreboard
// of expected (requester, row) results queued as requester beats are accepted.
module tb_idct_block_arbiter;
    localparam int WIN       = 16;
    localparam int WOUT      = 9;
    localparam int TAG_DEPTH = 4;
    localparam int DI        = WIN * 8;
    localparam int DO        = WOUT * 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [DI-1:0]   s0_tdata, s1_tdata, core_s_tdata;
    logic            s0_tvalid, s0_tready, s1_tvalid, s1_tready;
    logic [DO-1:0]   m0_tdata, m1_tdata, core_m_tdata;
    logic            m0_tvalid, m0_tready, m1_tvalid, m1_tready;
    logic            core_s_tvalid, core_s_tready, core_m_tvalid, core_m_tready;
    logic            err;
`ifdef IDCT_ARB_STATS_EN
    logic [15:0]     blk_cnt0, blk_cnt1;
`endif

    idct_block_arbiter #(.WIN(WIN), .WOUT(WOUT), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
`ifdef IDCT_ARB_STATS_EN
        .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1),
`endif
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
        .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
        .core_s_tdata(core_s_tdata), .core_s_tvalid(core_s_tvalid), .core_s_tready(core_s_tready),
        .core_m_tdata(core_m_tdata), .core_m_tvalid(core_m_tvalid), .core_m_tready(core_m_tready),
        .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            id;
        logic [DO-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DI-1:0] src_q0[$];
    logic [DI-1:0] src_q1[$];
    logic [DI-1:0] core_q[$];
    int            grant_log[$];
    int            grant_cyc[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int in_cnt = 0;
    int res_beat = 0;
    int res0, res1, m1_seen, first_in_cyc, last_in_cyc, first_pop_cyc;
    logic s_en0, s_en1, inject;
    logic pend_s0, pend_s1, pend_cin, pend_cout;
    logic [DI-1:0] pend_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        logic [DI-1:0] c;
        s0_tvalid = s_en0 && (src_q0.size() > 0);
        s0_tdata  = (src_q0.size() > 0) ? src_q0[0] : {DI{1'b0}};
        s1_tvalid = s_en1 && (src_q1.size() > 0);
        s1_tdata  = (src_q1.size() > 0) ? src_q1[0] : {DI{1'b0}};
        c = (core_q.size() > 0) ? core_q[0] : {DI{1'b0}};
        core_m_tvalid = inject || (core_q.size() > 0);
        core_m_tdata  = c[DO-1:0];
    endtask

    task automatic got(input int id, input logic [DO-1:0] data);
        exp_t e;
        check("result_expected", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result_owner", 128'(id), 128'(e.id));
            check("result_data", 128'(data), 128'(e.data));
        end
        if (id == 0) res0++; else res1++;
        res_beat = (res_beat + 1) % 8;
        if (res_beat == 0 && first_pop_cyc < 0) first_pop_cyc = cyc;
    endtask

    task automatic sample();
        exp_t e;
        logic [DI-1:0] sd;
        cyc++;
        pend_s0 = 1'b0; pend_s1 = 1'b0; pend_cin = 1'b0; pend_cout = 1'b0;
        if (m1_tvalid) m1_seen = 1;
        if (reset_n) begin
            pend_s0 = s0_tvalid && s0_tready;
            pend_s1 = s1_tvalid && s1_tready;
            if (pend_s0 || pend_s1) begin
                sd = pend_s1 ? s1_tdata : s0_tdata;
                check("tready_exclusive", 128'(s0_tready & s1_tready), 128'(0));
                check("core_fwd_data", 128'(core_s_tdata), 128'(sd));
                if (in_cnt == 0) begin
                    grant_log.push_back(pend_s1 ? 1 : 0);
                    grant_cyc.push_back(cyc);
                end
                in_cnt = (in_cnt + 1) % 8;
                e.id = pend_s1 ? 1 : 0;
                e.data = sd[DO-1:0];
                exp_q.push_back(e);
            end
            pend_cin  = core_s_tvalid && core_s_tready;
            pend_data = core_s_tdata;
            if (pend_cin) begin
                if (first_in_cyc < 0) first_in_cyc = cyc;
                last_in_cyc = cyc;
            end
            pend_cout = core_m_tvalid && core_m_tready;
            if (m0_tvalid && m0_tready) got(0, m0_tdata);
            if (m1_tvalid && m1_tready) got(1, m1_tdata);
        end
    endtask

    task automatic update();
        logic [DI-1:0] junk;
        if (!reset_n) begin
            core_q.delete();
            exp_q.delete();
            in_cnt = 0;
            res_beat = 0;
        end else begin
            if (pend_cout && core_q.size() > 0) junk = core_q.pop_front();
            if (pend_cin) core_q.push_back(pend_data);
            if (pend_s0) junk = src_q0.pop_front();
            if (pend_s1) junk = src_q1.pop_front();
        end
        drive();
    endtask

    task automatic tick();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        update();
        #1;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((src_q0.size() > 0 || src_q1.size() > 0 || core_q.size() > 0 || exp_q.size() > 0) && n < max) begin
            tick();
            n++;
        end
        check("idle_within_budget", 128'(n < max), 128'(1));
    endtask

    task automatic push_block(input int id, input int blk);
        logic [DI-1:0] d;
        for (int b = 0; b < 8; b++) begin
            d = {DI{1'b0}};
            d[DI-1 -: 8] = 8'hC3;
            d[23:16] = 8'(id);
            d[15:8] = 8'(blk);
            d[7:0] = 8'(b + 1);
            if (id == 0) src_q0.push_back(d); else src_q1.push_back(d);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        grant_cyc.delete();
        res0 = 0; res1 = 0; m1_seen = 0;
        first_in_cyc = -1; last_in_cyc = -1; first_pop_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s0_tready"}, 128'(s0_tready), 128'(0));
        check({tag, "_s1_tready"}, 128'(s1_tready), 128'(0));
        check({tag, "_m0_tvalid"}, 128'(m0_tvalid), 128'(0));
        check({tag, "_m1_tvalid"}, 128'(m1_tvalid), 128'(0));
        check({tag, "_m0_tdata"}, 128'(m0_tdata), 128'(0));
        check({tag, "_m1_tdata"}, 128'(m1_tdata), 128'(0));
        check({tag, "_core_s_tvalid"}, 128'(core_s_tvalid), 128'(0));
        check({tag, "_core_m_tready"}, 128'(core_m_tready), 128'(1));
        check({tag, "_err"}, 128'(err), 128'(0));
    endtask

    initial begin
        int n;
        reset_n = 1'b0; s_en0 = 1'b1; s_en1 = 1'b1; inject = 1'b0;
        m0_tready = 1'b1; m1_tready = 1'b1; core_s_tready = 1'b1;
        clear_logs();
        drive();
        tick(); tick();
        check_reset_outputs("reset");

        // Single block from s0 only.
        reset_n = 1'b1;
        push_block(0, 0);
        drive();
        wait_idle(100);
        check("t1_grant_count", 128'(grant_log.size()), 128'(1));
        if (grant_log.size() >= 1) check("t1_grant_id", 128'(grant_log[0]), 128'(0));
        check("t1_m0_results", 128'(res0), 128'(8));
        check("t1_m1_silent", 128'(m1_seen), 128'(0));
        m0_tready = 1'b0; drive(); #1;
        check("t1_fifo_empty", 128'(core_m_tready), 128'(1));
        m0_tready = 1'b1; drive();

        // Both requesters continuously valid for four blocks.
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        clear_logs();
        push_block(0, 0); push_block(1, 0); push_block(0, 1); push_block(1, 1);
        drive();
        wait_idle(200);
        check("t2_grant_count", 128'(grant_log.size()), 128'(4));
        for (int i = 0; i < grant_log.size(); i++) check("t2_grant_order", 128'(grant_log[i]), 128'(i % 2));
        check("t2_input_span", 128'(last_in_cyc - first_in_cyc), 128'(34));
        check("t2_results0", 128'(res0), 128'(16));
        check("t2_results1", 128'(res1), 128'(16));
`ifdef IDCT_ARB_STATS_EN
        check("t2_blk_cnt0", 128'(blk_cnt0), 128'(2));
        check("t2_blk_cnt1", 128'(blk_cnt1), 128'(2));
`endif

        // Tag FIFO full: fifth grant waits for the first pop.
        clear_logs();
        m0_tready = 1'b0;
        for (int b = 0; b < 5; b++) push_block(0, 16 + b);
        drive();
        repeat (60) tick();
        check("t3_grants_while_full", 128'(grant_log.size()), 128'(4));
        check("t3_s0_blocked", 128'(s0_tready), 128'(0));
        check("t3_core_backpressure", 128'(core_m_tready), 128'(0));
        m0_tready = 1'b1; drive();
        wait_idle(300);
        check("t3_grant_count", 128'(grant_log.size()), 128'(5));
        if (grant_log.size() == 5) check("t3_fifth_grant_cycle", 128'(grant_cyc[4]), 128'(first_pop_cyc + 2));
        check("t3_results0", 128'(res0), 128'(40));

        // s1 stalls mid-block while s0 waits: no preemption.
        clear_logs();
        push_block(1, 5);
        drive();
        n = 0;
        while (in_cnt < 3 && n < 50) begin tick(); n++; end
        check("t4_three_beats", 128'(in_cnt), 128'(3));
        s_en1 = 1'b0;
        push_block(0, 6);
        drive();
        repeat (5) begin
            tick();
            check("t4_s0_held", 128'(s0_tready), 128'(0));
            check("t4_core_idle", 128'(core_s_tvalid), 128'(0));
        end
        s_en1 = 1'b1; drive();
        wait_idle(200);
        check("t4_grant_count", 128'(grant_log.size()), 128'(2));
        if (grant_log.size() == 2) begin
            check("t4_first_grant", 128'(grant_log[0]), 128'(1));
            check("t4_second_grant", 128'(grant_log[1]), 128'(0));
        end
        check("t4_results1", 128'(res1), 128'(8));
        check("t4_results0", 128'(res0), 128'(8));

        // Core output with no tag pending.
        check("t5_err_before", 128'(err), 128'(0));
        inject = 1'b1; drive(); #1;
        check("t5_m0_quiet", 128'(m0_tvalid), 128'(0));
        check("t5_m1_quiet", 128'(m1_tvalid), 128'(0));
        check("t5_drain_ready", 128'(core_m_tready), 128'(1));
        tick();
        inject = 1'b0; drive();
        check("t5_err_set", 128'(err), 128'(1));
        repeat (3) tick();
        check("t5_err_sticky", 128'(err), 128'(1));
        reset_n = 1'b0; tick();
        check("t5_err_cleared", 128'(err), 128'(0));

        // Reset in the middle of a block, then a fresh block.
        reset_n = 1'b1;
        clear_logs();
        push_block(0, 7);
        drive();
        n = 0;
        while (in_cnt < 4 && n < 50) begin tick(); n++; end
        check("t6_four_beats", 128'(in_cnt), 128'(4));
        reset_n = 1'b0; drive();
        tick();
        check_reset_outputs("t6_reset");
        src_q0.delete();
        reset_n = 1'b1;
        clear_logs();
        push_block(0, 8);
        drive();
        wait_idle(100);
        check("t6_grant_count", 128'(grant_log.size()), 128'(1));
        if (grant_log.size() == 1) check("t6_grant_id", 128'(grant_log[0]), 128'(0));
        check("t6_results0", 128'(res0), 128'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/idct_block_arbiter.md
# idct_block_arbiter

Shares one wide AXI-stream IDCT core between two independent requester streams, at 8×8 block granularity. Each requester sends a block as 8 row beats. The arbiter grants the core to one requester for a whole block using round-robin, and records the requester ID in a tag FIFO. It then steers the core's 8 result beats back to the matching requester, in order. It sits between the two coefficient sources and the wide IDCT stream wrapper, on the same clock and reset.

## Interface
- WIN, 16: width of one input coefficient; an input beat is WIN*8 bits.
- WOUT, 9: width of one output sample; an output beat is WOUT*8 bits.
- TAG_DEPTH, 4: number of tag-FIFO entries, i.e. blocks that can be in flight; must be a power of two, at least 2.
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- s0_tdata / s1_tdata  in  WIN*8  requester row beat.
- s0_tvalid / s1_tvalid  in  1  requester beat valid.
- s0_tready / s1_tready  out  1  requester beat accepted.
- m0_tdata / m1_tdata  out  WOUT*8  result row back to the requester.
- m0_tvalid / m1_tvalid  out  1  result valid.
- m0_tready / m1_tready  in  1  requester ready for a result.
- core_s_tdata  out  WIN*8  row to the IDCT core; core_s_tvalid out 1; core_s_tready in 1.
- core_m_tdata  in  WOUT*8  row from the IDCT core; core_m_tvalid in 1; core_m_tready out 1.
- err  out  1  sticky flag: the core produced output while the tag FIFO was empty.

## Operation
- Input FSM has two states, IDLE and XFER.
- IDLE → XFER when at least one sN_tvalid is high and the tag FIFO is not full.
  - Winner: if only one requester is valid, that one. If both are valid, the one that is not `last`.
  - The winner is stored in the registered `grant`, which also updates `last`.
  - The winner's ID is pushed into the tag FIFO on the same edge.
- In XFER:
  - core_s_tdata/tvalid mirror the granted requester; s<grant>_tready = core_s_tready; the other sN_tready is 0.
  - A 3-bit in_beat counter increments on each accepted beat (valid & ready).
  - On the 8th beat (in_beat==7 accepted) the FSM returns to IDLE and in_beat wraps to 0.
- No preemption. If the granted requester drops tvalid mid-block, XFER holds with the core idle.
- Output side, when the tag FIFO is not empty (head = ID):
  - m<head>_tdata = core_m_tdata; m<head>_tvalid = core_m_tvalid; core_m_tready = m<head>_tready.
  - The other m port has tvalid 0 and tdata 0.
  - A 3-bit out_beat counter increments on each accepted result beat. The tag is popped when out_beat==7 is accepted.
- Output side, when the tag FIFO is empty: core_m_tready = 1 (beats are drained and dropped), and core_m_tvalid high sets err.
- Tag FIFO:
  - Occupancy counter is $clog2(TAG_DEPTH)+1 bits wide; read and write pointers wrap modulo TAG_DEPTH.
  - Push and pop in the same cycle leave the count unchanged; this is legal even when full.
  - A grant is evaluated against the pre-pop count, so a block is never granted while the FIFO is full.
- Reset mid-block clears the FSM, counters, FIFO, `last` (set to 1, so requester 0 wins the first tie) and err. Partial blocks are discarded. The core shares reset_n, so no stale results return.

## Timing
- Reset values: every sN_tready 0, mN_tvalid 0, mN_tdata 0, core_s_tvalid 0, core_m_tready 1, err 0, FSM IDLE.
- Arbitration costs one IDLE cycle per block, so back-to-back blocks take 9 input cycles each. This matches the core wrapper's 8 accept cycles plus 1 bubble.
- No register stage on the data paths. Forward and backward signals are combinational muxes selected by registered `grant` and FIFO head. Added latency is 0 cycles beyond the core's.
- A tvalid that rises during IDLE is first accepted one cycle after grant, at the earliest.
- err sets on the edge after the offending beat and stays set until reset.

## Configuration
- IDCT_ARB_STATS_EN defined:
  - Adds outputs blk_cnt0 and blk_cnt1, each 16 bits, reset to 0.
  - blk_cntN increments when requester N's 8th result beat is accepted, and wraps 0xFFFF→0.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Single requester, s0 only, one block of rows 0x01..0x08 with core ready → grant=0, 8 beats on the core, results appear only on m0 (m1_tvalid stays 0), tag FIFO back to empty.
- Both requesters continuously valid for 4 blocks → grant order 0,1,0,1 and results return 0,1,0,1. With IDCT_ARB_STATS_EN, blk_cnt0=2 and blk_cnt1=2.
- Hold m0_tready=0 while 4 blocks are submitted (TAG_DEPTH=4) → the 5th grant is blocked and s0/s1 tready stay 0 until the first tag pop, after which the next grant occurs.
- s1 drops tvalid after 3 beats for 5 cycles while s0 is valid → no switch to s0; s1's remaining 5 beats complete, then s0 is granted.
- Drive core_m_tvalid=1 with the FIFO empty → err=1 the next cycle, the beat is dropped, and err stays 1 until reset_n=0.
- Assert reset_n=0 at in_beat=4 → the next cycle shows all outputs at reset values, and a fresh block from s0 completes correctly.
